wide_add_seq: RTL and testbench

//  Multi-cycle sequencer for a wide adder. Accepts a WIDTH-bit operand pair and

---
 rtl/wide_add_seq.sv | 136 +++++++++++++
 tb/tb_wide_add_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one CHUNK-bit slice per cycle, carry rippled in a register.
// Define WIDE_ADD_SUB_EN to add the sub port (x - y in two's complement).
module wide_add_seq #(
  parameter int WIDTH = 100,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef WIDE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LASTB = WIDTH - (NCHUNK - 1) * CHUNK;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_init;
  logic [WIDTH-1:0] y_in;

  logic [CHUNK-1:0] xs;
  logic [CHUNK-1:0] ys;
  logic [CHUNK:0]   s;

`ifdef WIDE_ADD_SUB_EN
  assign in_init = sub;
  assign y_in    = sub ? ~y : y;
`else
  assign in_init = 1'b0;
  assign y_in    = y;
`endif

  // Bits past WIDTH read as zero, so the carry out of
  // bit WIDTH-1 lands at s[LASTB] in the last slice.
  always_comb begin
    int base;
    xs   = '0;
    ys   = '0;
    base = int'(idx_q) * CHUNK;
    for (int j = 0; j < CHUNK; j++) begin
      if (base + j < WIDTH) begin
        xs[j] = x_q[base+j];
        ys[j] = y_q[base+j];
      end
    end
  end

  assign s = {1'b0, xs} + {1'b0, ys}
           + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i / CHUNK == int'(idx_q)) begin
        sum_d[i] = s[i%CHUNK];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x;
            y_q        <= y_in;
            carry_q    <= in_init;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= s[CHUNK];
          idx_q   <= idx_q + IW'(1);
          if (idx_q == IW'(NCHUNK - 1)) begin
            cout_q      <= s[LASTB];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq (WIDTH=100, CHUNK=32, four slices).
// Sub-mode vectors run only when WIDE_ADD_SUB_EN is defined.
module tb_wide_add_seq;

  localparam int W = 100;
  localparam int C = 32;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
`ifdef WIDE_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_assert;
  int n_fail;

  wide_add_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
`ifdef WIDE_ADD_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents operands for one edge (E0),
  // then leaves the bench at the negedge after E0.
  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic s);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_op", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    x = a;
    y = b;
`ifdef WIDE_ADD_SUB_EN
    sub = s;
`else
    if (s) $display("sub vector skipped");
`endif
    @(negedge clk);
    in_valid = 1'b0;
    x = {W{1'b1}} ^ a;
    y = ~b;
    chk("in_ready_run", 128'(in_ready), 128'(0));
  endtask

  task automatic wait_done();
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      chk($sformatf("out_valid_E0+%0d", k),
          128'(out_valid), 128'(k == N));
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", 128'(out_valid), 128'(0));
    chk("in_ready_after_hs", 128'(in_ready), 128'(1));
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic s,
                        input logic [W-1:0] es,
                        input logic ec);
    start_op(a, b, s);
    wait_done();
    chk({tag, "_sum"}, 128'(sum), 128'(es));
    chk({tag, "_cout"}, 128'(carry_out), 128'(ec));
    finish_op();
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
`ifdef WIDE_ADD_SUB_EN
    sub       = 1'b0;
`endif
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_sum", 128'(sum), 128'(0));
    chk("rst_cout", 128'(carry_out), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1", 100'h3 - 100'h2, 100'h2, 1'b0,
           100'h3, 1'b0);
    run_op("t2", 100'hffff_ffff_ffff_ffff, 100'h1, 1'b0,
           100'h1_0000_0000_0000_0000, 1'b0);
    run_op("t3", {W{1'b1}}, 100'h1, 1'b0,
           100'h0, 1'b1);
    run_op("t_b31", 100'h1_0000_0000_8000_0000,
           100'h8000_0000, 1'b0,
           100'h1_0000_0001_0000_0000, 1'b0);
    run_op("t_p96", {4'h0, {96{1'b1}}}, 100'h1, 1'b0,
           100'h1_0000_0000_0000_0000_0000_0000, 1'b0);
    run_op("t_msb", 100'h8_0000_0000_0000_0000_0000_0000,
           100'h8_0000_0000_0000_0000_0000_0001, 1'b0,
           100'h1, 1'b1);

    // Backpressure: DONE must hold while new operands are offered.
    start_op(100'h10, 100'h20, 1'b0);
    wait_done();
    in_valid = 1'b1;
    x = 100'h55;
    y = 100'h66;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_sum", 128'(sum), 128'(100'h30));
      chk("bp_cout", 128'(carry_out), 128'(0));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    finish_op();
    chk("bp_sum_after", 128'(sum), 128'(100'h30));

    // Reset in the middle of RUN.
    start_op(100'h5, 100'h3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_run_sum", 128'(sum), 128'(100'h8));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_sum", 128'(sum), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    chk("post_rst_out_valid", 128'(out_valid), 128'(0));
    run_op("t5", 100'h7, 100'h2, 1'b0, 100'h9, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    run_op("t6a", 100'h7, 100'h2, 1'b1, 100'h5, 1'b1);
    run_op("t6b", 100'h2, 100'h7, 1'b1,
           100'hf_ffff_ffff_ffff_ffff_ffff_fffb, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: simulation did not finish");
  end

endmodule
